// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, bit shifting on device
// clock falling edges, acknowledge sampling and timeout abort.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FC_W  = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RELEASE,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_clk_meta;
    logic             r_clk_sync;
    logic             r_dat_meta;
    logic             r_dat_sync;
    logic             r_clk_filt;
    logic             r_clk_filt_d;
    logic [FC_W-1:0]  r_filt_cnt;
    logic             w_fe;

    logic             r_data_oe;
    logic [7:0]       r_byte;
    logic             r_par;
    logic [3:0]       r_bit;
    logic [INH_W-1:0] r_inh_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_ack_err;
    logic             r_tmo_err;

    logic             w_data_oe_nxt;
    logic [7:0]       w_byte_nxt;
    logic             w_par_nxt;
    logic [3:0]       w_bit_nxt;
    logic [INH_W-1:0] w_inh_nxt;
    logic [TMO_W-1:0] w_tmo_nxt;
    logic             w_ack_err_nxt;
    logic             w_tmo_err_nxt;
    logic [9:0]       w_frame;
    logic             w_tmo_hit;

    // Synchronizers idle high to match a released open-collector bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_meta   <= 1'b1;
            r_clk_sync   <= 1'b1;
            r_dat_meta   <= 1'b1;
            r_dat_sync   <= 1'b1;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
            r_filt_cnt   <= '0;
        end else begin
            r_clk_meta   <= ps2_clk_in;
            r_clk_sync   <= r_clk_meta;
            r_dat_meta   <= ps2_data_in;
            r_dat_sync   <= r_dat_meta;
            r_clk_filt_d <= r_clk_filt;
            if (r_clk_sync != r_clk_filt) begin
                if (r_filt_cnt == FC_W'(FILTER_LEN - 1)) begin
                    r_clk_filt <= r_clk_sync;
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 1'b1;
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    assign w_fe      = r_clk_filt_d & ~r_clk_filt;
    assign w_frame   = {1'b1, r_par, r_byte};
    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) && !w_fe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_data_oe <= 1'b0;
            r_byte    <= '0;
            r_par     <= 1'b0;
            r_bit     <= '0;
            r_inh_cnt <= '0;
            r_tmo_cnt <= '0;
            r_ack_err <= 1'b0;
            r_tmo_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_data_oe <= w_data_oe_nxt;
            r_byte    <= w_byte_nxt;
            r_par     <= w_par_nxt;
            r_bit     <= w_bit_nxt;
            r_inh_cnt <= w_inh_nxt;
            r_tmo_cnt <= w_tmo_nxt;
            r_ack_err <= w_ack_err_nxt;
            r_tmo_err <= w_tmo_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_data_oe_nxt = r_data_oe;
        w_byte_nxt    = r_byte;
        w_par_nxt     = r_par;
        w_bit_nxt     = r_bit;
        w_inh_nxt     = r_inh_cnt;
        w_tmo_nxt     = r_tmo_cnt;
        w_ack_err_nxt = r_ack_err;
        w_tmo_err_nxt = r_tmo_err;
        ps2_clk_oe    = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (tx_start) begin
                    w_byte_nxt    = tx_data;
                    w_par_nxt     = ~^tx_data;
                    w_ack_err_nxt = 1'b0;
                    w_tmo_err_nxt = 1'b0;
                    w_inh_nxt     = '0;
                    w_data_oe_nxt = 1'b0;
                    w_state_nxt   = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                    w_data_oe_nxt = 1'b1;
                    w_state_nxt   = S_RELEASE;
                end else begin
                    w_inh_nxt = r_inh_cnt + 1'b1;
                end
            end

            S_RELEASE: begin
                w_bit_nxt   = '0;
                w_tmo_nxt   = '0;
                w_state_nxt = S_SHIFT;
            end

            // Edge index 0..7 data LSB first, 8 parity, 9 stop (oe released).
            S_SHIFT: begin
                if (w_fe) begin
                    w_data_oe_nxt = ~w_frame[r_bit];
                    w_tmo_nxt     = '0;
                    if (r_bit == 4'd9) begin
                        w_state_nxt = S_ACK;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end else if (w_tmo_hit) begin
                    w_data_oe_nxt = 1'b0;
                    w_tmo_err_nxt = 1'b1;
                    w_ack_err_nxt = 1'b1;
                    w_state_nxt   = S_DONE;
                end else begin
                    w_tmo_nxt = r_tmo_cnt + 1'b1;
                end
            end

            S_ACK: begin
                if (w_fe) begin
                    w_ack_err_nxt = r_dat_sync;
                    w_tmo_nxt     = '0;
                    w_state_nxt   = S_WAIT_IDLE;
                end else if (w_tmo_hit) begin
                    w_data_oe_nxt = 1'b0;
                    w_tmo_err_nxt = 1'b1;
                    w_ack_err_nxt = 1'b1;
                    w_state_nxt   = S_DONE;
                end else begin
                    w_tmo_nxt = r_tmo_cnt + 1'b1;
                end
            end

            // Acknowledge already sampled here, so a timeout keeps its result.
            S_WAIT_IDLE: begin
                if (r_clk_filt && r_dat_sync) begin
                    w_state_nxt = S_DONE;
                end else if (w_tmo_hit) begin
                    w_data_oe_nxt = 1'b0;
                    w_tmo_err_nxt = 1'b1;
                    w_state_nxt   = S_DONE;
                end else if (w_fe) begin
                    w_tmo_nxt = '0;
                end else begin
                    w_tmo_nxt = r_tmo_cnt + 1'b1;
                end
            end

            S_DONE: begin
                busy        = 1'b0;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign ps2_data_oe = r_data_oe;
    assign ack_err     = r_ack_err;
    assign timeout_err = r_tmo_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model on open-collector lines
// captures each frame and drives clock, acknowledge, stalls and glitches.
module tb_ps2_host_tx;

    localparam int INH = 50;
    localparam int TMO = 2000;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_start = 1'b0;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    int         cyc = 0;
    int         last_fall_cyc = 0;
    int         done_cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy(busy),
        .done(done),
        .ack_err(ack_err),
        .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tx(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
    endtask

    // Counts cycles the host holds clock low; stops on the first released cycle.
    task automatic wait_inhibit(output int n);
        n = 0;
        while (ps2_clk_oe === 1'b1 && n < 10000) begin
            n++;
            tick();
        end
    endtask

    task automatic device_clock(input int n_edges, input bit ack, input int glitch_edge,
                                output logic [10:0] frame);
        frame = '0;
        repeat (20) tick();
        frame[0] = ps2_data_in;
        for (int e = 1; e <= n_edges; e++) begin
            dev_clk_low   = 1'b1;
            last_fall_cyc = cyc;
            repeat (HALF) tick();
            dev_clk_low = 1'b0;
            if (e <= 10) frame[e] = ps2_data_in;
            if (e == 11) dev_data_low = 1'b0;
            if (e == 10 && ack) dev_data_low = 1'b1;
            if (e < n_edges) begin
                if (e == glitch_edge) begin
                    repeat (15) tick();
                    dev_clk_low = 1'b1;
                    repeat (2) tick();
                    dev_clk_low = 1'b0;
                    repeat (HALF - 17) tick();
                end else begin
                    repeat (HALF) tick();
                end
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 5000) begin
            n++;
            tick();
        end
        done_cyc = cyc;
        check({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic do_transfer(input string tag, input logic [7:0] d, input logic par,
                               input bit ack, input bit spurious, input int glitch_edge);
        int          n;
        logic [10:0] frame;
        logic [10:0] exp_frame;
        exp_frame = {1'b1, par, d, 1'b0};
        start_tx(d);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_errs_clr"}, {30'd0, ack_err, timeout_err}, 32'd0);
        wait_inhibit(n);
        check({tag, "_inhibit_len"}, 32'(n), 32'(INH));
        check({tag, "_start_oe"}, 32'(ps2_data_oe), 32'd1);
        if (spurious) begin
            tx_data  = 8'h55;
            tx_start = 1'b1;
            tick();
            tx_start = 1'b0;
        end
        device_clock(11, ack, glitch_edge, frame);
        check({tag, "_frame"}, 32'(frame), 32'(exp_frame));
        wait_done(tag);
        check({tag, "_ack_err"}, 32'(ack_err), 32'(!ack));
        check({tag, "_tmo_err"}, 32'(timeout_err), 32'd0);
        check({tag, "_lines"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_ack_hold"}, 32'(ack_err), 32'(!ack));
        repeat (10) tick();
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [10:0] frame;

        rst = 1'b0;
        repeat (3) tick();
        check("reset_outputs",
              {26'd0, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err}, 32'd0);
        rst = 1'b1;
        repeat (5) tick();

        do_transfer("f4", 8'hF4, 1'b0, 1'b1, 1'b0, 0);
        do_transfer("ed", 8'hED, 1'b1, 1'b1, 1'b0, 0);
        do_transfer("00", 8'h00, 1'b1, 1'b1, 1'b0, 0);
        do_transfer("01", 8'h01, 1'b0, 1'b1, 1'b0, 0);
        do_transfer("nack", 8'hA5, 1'b1, 1'b0, 1'b0, 0);
        do_transfer("busy_glitch", 8'h3C, 1'b1, 1'b1, 1'b1, 3);

        // Device stalls after edge 5 with data_oe still asserted (bit 4 of 0x00).
        start_tx(8'h00);
        wait_inhibit(n);
        device_clock(5, 1'b0, 0, frame);
        check("tmo_oe_before", 32'(ps2_data_oe), 32'd1);
        wait_done("tmo");
        check("tmo_latency_ok",
              32'((done_cyc - last_fall_cyc) >= TMO && (done_cyc - last_fall_cyc) <= TMO + 20), 32'd1);
        check("tmo_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("tmo_errs", {30'd0, ack_err, timeout_err}, 32'd3);
        tick();
        check("tmo_done_pulse", 32'(done), 32'd0);
        repeat (10) tick();

        // Reset in SHIFT after edge 4; bit 3 of 0xF4 is 0 so data_oe is held.
        start_tx(8'hF4);
        wait_inhibit(n);
        device_clock(4, 1'b0, 0, frame);
        check("rst_pre_oe", {30'd0, busy, ps2_data_oe}, 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_outputs", {28'd0, ps2_clk_oe, ps2_data_oe, busy, done}, 32'd0);
        repeat (4) tick();
        rst = 1'b1;
        repeat (10) tick();
        do_transfer("post_rst", 8'hF4, 1'b0, 1'b1, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte (for example 0xED set-LEDs or 0xF4 enable) from the CPU to the keyboard over the same key_clk/key_data lines the receive path uses. It drives the open-collector lines through active-high pull-low enables, follows the host-request-to-send sequence, and reports completion, device acknowledge and timeout. It sits beside the PS/2 receiver in the CPU I/O block; the receiver must ignore the bus while busy=1.

Parameters:
INHIBIT_CYCLES, 5000, system clocks the PS/2 clock is held low before the start bit (100 us at 50 MHz).
TIMEOUT_CYCLES, 1000000, maximum system clocks between consecutive device clock falling edges, and while waiting for bus idle (20 ms at 50 MHz).
FILTER_LEN, 4, consecutive equal synchronized samples required to change the filtered PS/2 clock level.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous reset, active-low.
tx_data  in  8  command byte; sampled when tx_start is accepted.
tx_start  in  1  one-cycle request; accepted only when busy=0.
ps2_clk_in  in  1  raw PS/2 clock pin level (asynchronous).
ps2_data_in  in  1  raw PS/2 data pin level (asynchronous).
ps2_clk_oe  out  1  1 = pull PS/2 clock low; 0 = release.
ps2_data_oe  out  1  1 = pull PS/2 data low; 0 = release.
busy  out  1  high from the cycle after acceptance until the cycle done pulses.
done  out  1  one-cycle pulse when a transfer ends (success, nack or timeout).
ack_err  out  1  1 = device did not acknowledge; valid from done until the next acceptance.
timeout_err  out  1  1 = timeout abort; valid from done until the next acceptance.

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0, the lines are released, and the FSM is in IDLE. If reset asserts mid-transfer, both oe outputs drop immediately, with no completion pulse.
- Input conditioning: both raw inputs pass through 2-flop synchronizers. The synchronized clock drives a FILTER_LEN glitch filter. A falling edge event (fe) is a one-cycle pulse when the filtered clock goes 1->0.
- Acceptance: in IDLE with tx_start=1, the block latches tx_data, computes parity = ~^tx_data (odd parity), clears ack_err and timeout_err, and enters INHIBIT. tx_start at any other time is ignored.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles. On the last cycle, ps2_data_oe is set to 1 (start bit 0). The next state is RELEASE.
- RELEASE: ps2_clk_oe=0 while ps2_data_oe stays 1. The bit index resets to 0, the timeout counter clears, and the FSM enters SHIFT.
- SHIFT: on each fe, the cycle after fe, ps2_data_oe is set to the inverse of the next bit. The bit sequence is:
  - edges 1..8: tx_data[0..7], LSB first;
  - edge 9: parity;
  - edge 10: stop bit, so ps2_data_oe=0 and stays 0 for the rest of the transfer.
- ACK: on edge 11, the block samples the synchronized data. A value of 0 gives ack_err=0; a value of 1 gives ack_err=1. The next state is WAIT_IDLE.
- WAIT_IDLE: the FSM waits until the filtered clock and the synchronized data are both 1. It then enters DONE.
- DONE: done=1 for one cycle, busy drops in the same cycle, and the FSM returns to IDLE. A tx_start arriving in the DONE cycle is ignored.
- Timeout: the counter runs in SHIFT, ACK and WAIT_IDLE and clears on every fe. If it reaches TIMEOUT_CYCLES:
  - both oe outputs go to 0 and timeout_err=1;
  - ack_err=1 only if the timeout occurs before edge 11 was sampled;
  - the FSM goes to DONE.
- Counters are sized for the parameters; no count wraps inside a transfer.
- Data changes only after fe, never on rising edges. ps2_clk_oe is 1 only in INHIBIT.

Test Plan (sim with INHIBIT_CYCLES=50, TIMEOUT_CYCLES=2000, FILTER_LEN=4, device model clock half-period 40 clk):
1. Pulse tx_start with tx_data=0xF4 -> ps2_clk_oe high for exactly 50 cycles, then data_oe high. The device samples, on rising edges, start 0, bits 0,0,1,0,1,1,1,1, parity 0, stop 1. The device pulls data low on edge 11 -> done pulse, ack_err=0, timeout_err=0.
2. Send tx_data=0xED -> parity 1 (6 ones). Then send 0x00 -> parity 1. Then send 0x01 -> parity 0. In each case the device-captured frame matches exactly.
3. Device does not drive the ack -> done pulse with ack_err=1 and timeout_err=0, and both lines are released.
4. Device stops clocking after edge 5 -> 2000 cycles after the last fe, both oe outputs are 0, done pulses, timeout_err=1 and ack_err=1.
5. Pulse tx_start while busy=1 with different data -> ignored, and the original byte's frame completes unchanged. Also inject a 2-cycle low glitch on ps2_clk_in -> no fe and no bit advance.
6. Assert rst in the middle of SHIFT (after edge 4) -> in the same cycle ps2_clk_oe=ps2_data_oe=busy=done=0. After rst releases, a new 0xF4 transfer completes correctly.
